eq_mac_scheduler: RTL



---
 rtl/eq_mac_scheduler_pkg.sv | 23 ++
 rtl/eq_mac_scheduler_counter.sv | 27 ++
 rtl/eq_mac_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/eq_mac_scheduler_pkg.sv
// Shared types and sizing helpers for the equalizer MAC frame sequencer.
package eq_mac_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_LOAD    = 3'd4,
    S_SHIFT   = 3'd5
  } state_t;

  // Counter/address width; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Cycles from the accepting cycle until IDLE is reached again.
  function automatic int frame_cycles(input int bands, input int taps, input int mac_lat);
    return 2 + bands * (taps + mac_lat + 1);
  endfunction

endpackage

// File: rtl/eq_mac_scheduler_counter.sv
// Modulo-N up counter with synchronous clear, enable and terminal-count flag.
module mod_counter #(
  parameter int N = 2,
  parameter int W = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= tc ? '0 : count + W'(1);
  end

endmodule

// File: rtl/eq_mac_scheduler.sv
// Frame sequencer driving one shared MAC across BANDS FIR bands of TAPS taps.
//
// state   | meaning
// IDLE    | waiting for an enabled sample strobe
// CAPTURE | load input sample register, zero band/tap
// RUN     | one MAC step per tap of the current band
// DRAIN   | wait MAC_LAT cycles for the MAC pipeline
// LOAD    | strobe the current band's output register
// SHIFT   | shift delay line, signal end of frame
module eq_mac_scheduler
  import eq_mac_scheduler_pkg::*;
#(
  parameter int BANDS   = 3,
  parameter int TAPS    = 8,
  parameter int MAC_LAT = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            sample_valid,
  input  logic                            overrun_clr,
  output logic                            sample_load,
  output logic [cnt_w(BANDS*TAPS)-1:0]    coef_addr,
  output logic [cnt_w(TAPS)-1:0]          tap_sel,
  output logic                            mac_en,
  output logic                            mac_clr,
  output logic [BANDS-1:0]                band_load,
  output logic                            shift_en,
  output logic                            frame_done,
  output logic                            busy,
  output logic                            overrun
);

  localparam int AW = cnt_w(BANDS * TAPS);
  localparam int TW = cnt_w(TAPS);
  localparam int BW = cnt_w(BANDS);
  localparam int DN = (MAC_LAT < 1) ? 1 : MAC_LAT;
  localparam int DW = cnt_w(DN);
  localparam logic [AW-1:0]    TAPS_A   = AW'(TAPS);
  localparam logic [BANDS-1:0] BAND_ONE = BANDS'(1);

  state_t state, state_nxt;

  logic [TW-1:0] tap;
  logic [BW-1:0] band;
  logic [DW-1:0] unused_drain_cnt;
  logic          tap_tc, band_tc, drain_tc;
  logic          tap_en, band_en, drain_en, cnt_clr;
  logic          run;

  mod_counter #(.N(TAPS), .W(TW)) u_tap_cnt (
    .clk(clk), .reset(reset), .en(tap_en), .clr(cnt_clr), .count(tap), .tc(tap_tc)
  );

  mod_counter #(.N(BANDS), .W(BW)) u_band_cnt (
    .clk(clk), .reset(reset), .en(band_en), .clr(cnt_clr), .count(band), .tc(band_tc)
  );

  mod_counter #(.N(DN), .W(DW)) u_drain_cnt (
    .clk(clk), .reset(reset), .en(drain_en), .clr(cnt_clr), .count(unused_drain_cnt), .tc(drain_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Tap counter wraps to 0 on its last tap, so the next band starts at tap 0.
  always_comb begin
    state_nxt = state;
    tap_en    = 1'b0;
    band_en   = 1'b0;
    drain_en  = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (enable && sample_valid) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        cnt_clr   = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        tap_en = 1'b1;
        if (tap_tc) state_nxt = (MAC_LAT == 0) ? S_LOAD : S_DRAIN;
      end
      S_DRAIN: begin
        drain_en = 1'b1;
        if (drain_tc) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (band_tc) begin
          state_nxt = S_SHIFT;
        end else begin
          band_en   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_SHIFT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state and counters.
  always_comb begin
    run         = (state == S_RUN);
    sample_load = (state == S_CAPTURE);
    mac_en      = run;
    mac_clr     = run && (tap == '0);
    coef_addr   = run ? (AW'(band) * TAPS_A + AW'(tap)) : '0;
    tap_sel     = run ? tap : '0;
    band_load   = (state == S_LOAD) ? (BAND_ONE << band) : '0;
    shift_en    = (state == S_SHIFT);
    frame_done  = (state == S_SHIFT);
    busy        = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (sample_valid && (state != S_IDLE))
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end

endmodule
